// File: rtl/alphatensor_operand_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alphatensor_pkg                                                  |
// | Purpose  : Shared sizes, matrix type and FSM state encoding for the         |
// |            alphaTensor operand-fetch stage and its bus interface.           |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package alphatensor_pkg;

  localparam int MATRIX_MEM_DEPTH_BIT = 4;
  localparam int ELEM_WIDTH           = 32;
  localparam int ELEM_NUM             = 16;
  localparam int MAT_WIDTH            = ELEM_WIDTH * ELEM_NUM;

  // Element k occupies bits [k*ELEM_WIDTH +: ELEM_WIDTH].
  typedef logic [MAT_WIDTH-1:0]            matrix_t;
  typedef logic [MATRIX_MEM_DEPTH_BIT-1:0] mat_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    HOLD = 2'd3
  } opf_state_e;

endpackage
`default_nettype wire

// File: rtl/alphatensor_operand_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alphatensor_operand_fetch_if                                     |
// | Purpose  : Bundles the IDU request, IEX flush, matrix-memory read port and  |
// |            multiplier handshake seen by the operand-fetch stage.            |
// | Modports : master - operand-fetch stage (drives ready, read port, operands) |
// |            slave  - surrounding pipeline / memory / multiplier             |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface alphatensor_operand_fetch_if;
  import alphatensor_pkg::*;

  // IDU request
  mat_idx_t idu_alphaTensor_rd;
  mat_idx_t idu_alphaTensor_rs1;
  mat_idx_t idu_alphaTensor_rs2;
  logic     idu_alphaTensor_mul_vld;
  logic     alphaTensor_idu_ready;
  // IEX branch flush
  logic     iex_alphaTensor_bru_vld_0;
  logic     iex_alphaTensor_bru_flush_0;
  // Matrix-memory read port (synchronous read)
  logic     mmem_rd_en;
  mat_idx_t mmem_rd_addr;
  matrix_t  mmem_rd_data;
  // Multiplier handshake
  logic     opf_mul_vld;
  logic     mul_opf_ready;
  mat_idx_t opf_mul_rd;
  matrix_t  opf_mul_mat_a;
  matrix_t  opf_mul_mat_b;

  modport master (
    input  idu_alphaTensor_rd, idu_alphaTensor_rs1, idu_alphaTensor_rs2,
    input  idu_alphaTensor_mul_vld,
    output alphaTensor_idu_ready,
    input  iex_alphaTensor_bru_vld_0, iex_alphaTensor_bru_flush_0,
    output mmem_rd_en, mmem_rd_addr,
    input  mmem_rd_data,
    output opf_mul_vld, opf_mul_rd, opf_mul_mat_a, opf_mul_mat_b,
    input  mul_opf_ready
  );

  modport slave (
    output idu_alphaTensor_rd, idu_alphaTensor_rs1, idu_alphaTensor_rs2,
    output idu_alphaTensor_mul_vld,
    input  alphaTensor_idu_ready,
    output iex_alphaTensor_bru_vld_0, iex_alphaTensor_bru_flush_0,
    input  mmem_rd_en, mmem_rd_addr,
    output mmem_rd_data,
    input  opf_mul_vld, opf_mul_rd, opf_mul_mat_a, opf_mul_mat_b,
    output mul_opf_ready
  );

endinterface
`default_nettype wire

// File: rtl/alphatensor_operand_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alphatensor_operand_fetch                                        |
// | Purpose  : Accepts a matrix-multiply request (rd, rs1, rs2), reads both     |
// |            source matrices through the single read port, and presents      |
// |            {rd, mat_a, mat_b} to the 4x4 multiplier. A valid IEX flush      |
// |            kills any in-flight request.                                     |
// | Ports    : clk   - core clock, rising edge                                  |
// |            rst_n - asynchronous active-low reset                            |
// |            bus   - alphatensor_operand_fetch_if.master (request, flush,     |
// |                    memory read port, multiplier handshake)                  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alphatensor_operand_fetch
  import alphatensor_pkg::*;
(
  input wire clk,
  input wire rst_n,
  alphatensor_operand_fetch_if.master bus
);

  opf_state_e r_state;
  opf_state_e w_nextState;
  mat_idx_t   r_rd;
  mat_idx_t   r_rs2;
  matrix_t    r_matA;
  matrix_t    r_matB;

  logic       w_flush;
  logic       w_iduReady;
  logic       w_accept;
  logic       w_mulVld;
  logic       w_rdEn;
  mat_idx_t   w_rdAddr;
  logic       w_capA;
  logic       w_capB;

  assign w_flush = bus.iex_alphaTensor_bru_vld_0 & bus.iex_alphaTensor_bru_flush_0;

  // Ready in HOLD lets a new request slip in on the same cycle as the
  // outgoing handshake. Gated by rst_n so every output reads 0 in reset.
  assign w_iduReady = rst_n & ((r_state == IDLE) |
                               ((r_state == HOLD) & bus.mul_opf_ready & ~w_flush));
  assign w_accept   = bus.idu_alphaTensor_mul_vld & w_iduReady & ~w_flush;

  always_comb begin
    w_nextState = r_state;
    w_mulVld    = 1'b0;
    w_rdEn      = 1'b0;
    w_rdAddr    = '0;
    w_capA      = 1'b0;
    w_capB      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          // rs1 goes straight from the request to the read port, so only
          // rs2 needs to be kept for the second read.
          w_rdEn      = 1'b1;
          w_rdAddr    = bus.idu_alphaTensor_rs1;
          w_nextState = RD_A;
        end
      end
      RD_A: begin
        if (w_flush) begin
          w_nextState = IDLE;
        end else begin
          w_capA      = 1'b1;
          w_rdEn      = 1'b1;
          w_rdAddr    = r_rs2;
          w_nextState = RD_B;
        end
      end
      RD_B: begin
        if (w_flush) begin
          w_nextState = IDLE;
        end else begin
          w_capB      = 1'b1;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (w_flush) begin
          w_nextState = IDLE;
        end else begin
          w_mulVld = 1'b1;
          if (bus.mul_opf_ready) begin
            if (w_accept) begin
              w_rdEn      = 1'b1;
              w_rdAddr    = bus.idu_alphaTensor_rs1;
              w_nextState = RD_A;
            end else begin
              w_nextState = IDLE;
            end
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rd    <= '0;
      r_rs2   <= '0;
      r_matA  <= '0;
      r_matB  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_rd  <= bus.idu_alphaTensor_rd;
        r_rs2 <= bus.idu_alphaTensor_rs2;
      end
      if (w_capA) r_matA <= bus.mmem_rd_data;
      if (w_capB) r_matB <= bus.mmem_rd_data;
    end
  end

  assign bus.alphaTensor_idu_ready = w_iduReady;
  assign bus.mmem_rd_en            = w_rdEn;
  assign bus.mmem_rd_addr          = w_rdAddr;
  assign bus.opf_mul_vld           = w_mulVld;
  assign bus.opf_mul_rd            = r_rd;
  assign bus.opf_mul_mat_a         = r_matA;
  assign bus.opf_mul_mat_b         = r_matB;

endmodule
`default_nettype wire

// File: tb/tb_alphatensor_operand_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alphatensor_operand_fetch                                     |
// | Purpose  : Directed self-checking bench for alphatensor_operand_fetch with  |
// |            a behavioural synchronous-read matrix memory.                    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_alphatensor_operand_fetch;
  import alphatensor_pkg::*;

  logic clk;
  logic rst_n;
  int   nPass;
  int   nChk;

  alphatensor_operand_fetch_if bus ();

  alphatensor_operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural matrix memory: data valid the cycle after rd_en.
  matrix_t mem [16];
  always_ff @(posedge clk) begin
    if (bus.mmem_rd_en) bus.mmem_rd_data <= mem[bus.mmem_rd_addr];
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nChk++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input mat_idx_t rd, input mat_idx_t rs1, input mat_idx_t rs2);
    bus.idu_alphaTensor_mul_vld = v;
    bus.idu_alphaTensor_rd      = rd;
    bus.idu_alphaTensor_rs1     = rs1;
    bus.idu_alphaTensor_rs2     = rs2;
  endtask

  task automatic flush(input logic v, input logic f);
    bus.iex_alphaTensor_bru_vld_0   = v;
    bus.iex_alphaTensor_bru_flush_0 = f;
  endtask

  initial begin
    int      m2 [16];
    matrix_t tmp;
    m2 = '{3, 9, 8, 1, 5, 6, 9, 1, 33, 41, 6161, 3434, 32535, 12313, 124124, 46456};
    nPass = 0;
    nChk  = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 16; k++) tmp[k*32 +: 32] = 32'(i * 256 + k + 100);
      mem[i] = tmp;
    end
    for (int k = 0; k < 16; k++) tmp[k*32 +: 32] = 32'(m2[k]);
    mem[2] = tmp;
    for (int k = 0; k < 16; k++) tmp[k*32 +: 32] = 32'(k + 1);
    mem[3] = tmp;

    rst_n = 1'b0;
    req(1'b0, 4'd0, 4'd0, 4'd0);
    flush(1'b0, 1'b0);
    bus.mul_opf_ready = 1'b1;

    // ---- reset state ----
    cyc(); cyc();
    chk("rst_ready", bus.alphaTensor_idu_ready, 0);
    chk("rst_rden", bus.mmem_rd_en, 0);
    chk("rst_vld", bus.opf_mul_vld, 0);
    chk("rst_rd", bus.opf_mul_rd, 0);
    chk("rst_mata", bus.opf_mul_mat_a, 0);
    chk("rst_matb", bus.opf_mul_mat_b, 0);
    #2 rst_n = 1'b1;
    cyc();
    chk("idle_ready", bus.alphaTensor_idu_ready, 1);
    chk("idle_addr", bus.mmem_rd_addr, 0);

    // ---- basic fetch rd=1 rs1=2 rs2=3 (ready=1 throughout, ignored outside HOLD) ----
    req(1'b1, 4'd1, 4'd2, 4'd3); #1;
    chk("b_N_rden", bus.mmem_rd_en, 1);
    chk("b_N_addr", bus.mmem_rd_addr, 2);
    cyc(); req(1'b0, 4'd0, 4'd0, 4'd0); #1;
    chk("b_N1_rden", bus.mmem_rd_en, 1);
    chk("b_N1_addr", bus.mmem_rd_addr, 3);
    chk("b_N1_vld", bus.opf_mul_vld, 0);
    chk("b_N1_ready", bus.alphaTensor_idu_ready, 0);
    cyc();
    chk("b_N2_rden", bus.mmem_rd_en, 0);
    chk("b_N2_addr", bus.mmem_rd_addr, 0);
    chk("b_N2_vld", bus.opf_mul_vld, 0);
    cyc();
    chk("b_N3_vld", bus.opf_mul_vld, 1);
    chk("b_N3_rd", bus.opf_mul_rd, 1);
    tmp = bus.opf_mul_mat_a;
    chk("b_a_e0", tmp[0 +: 32], 3);
    chk("b_a_e15", tmp[480 +: 32], 46456);
    tmp = bus.opf_mul_mat_b;
    chk("b_b_e0", tmp[0 +: 32], 1);
    chk("b_b_e15", tmp[480 +: 32], 16);
    chk("b_mata", bus.opf_mul_mat_a, mem[2]);
    cyc();
    chk("b_N4_vld", bus.opf_mul_vld, 0);
    chk("b_N4_ready", bus.alphaTensor_idu_ready, 1);

    // ---- backpressure rd=5 rs1=3 rs2=2 ----
    bus.mul_opf_ready = 1'b0;
    req(1'b1, 4'd5, 4'd3, 4'd2);
    cyc(); req(1'b0, 4'd0, 4'd0, 4'd0);
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", bus.opf_mul_vld, 1);
      chk("bp_rd", bus.opf_mul_rd, 5);
      chk("bp_mata", bus.opf_mul_mat_a, mem[3]);
      chk("bp_matb", bus.opf_mul_mat_b, mem[2]);
      chk("bp_ready", bus.alphaTensor_idu_ready, 0);
      cyc();
    end
    bus.mul_opf_ready = 1'b1; #1;
    chk("bp_N8_vld", bus.opf_mul_vld, 1);
    chk("bp_N8_ready", bus.alphaTensor_idu_ready, 1);
    cyc();
    chk("bp_N9_vld", bus.opf_mul_vld, 0);

    // ---- back-to-back: rd=1 rs1=2 rs2=3 then rd=4 rs1=3 rs2=2 ----
    req(1'b1, 4'd1, 4'd2, 4'd3);
    cyc(); req(1'b1, 4'd4, 4'd3, 4'd2);
    cyc(); cyc(); #1;
    chk("bb_N3_vld", bus.opf_mul_vld, 1);
    chk("bb_N3_rd", bus.opf_mul_rd, 1);
    chk("bb_N3_ready", bus.alphaTensor_idu_ready, 1);
    chk("bb_N3_rden", bus.mmem_rd_en, 1);
    chk("bb_N3_addr", bus.mmem_rd_addr, 3);
    cyc(); req(1'b0, 4'd0, 4'd0, 4'd0); #1;
    chk("bb_N4_addr", bus.mmem_rd_addr, 2);
    chk("bb_N4_vld", bus.opf_mul_vld, 0);
    cyc(); cyc();
    chk("bb_N6_vld", bus.opf_mul_vld, 1);
    chk("bb_N6_rd", bus.opf_mul_rd, 4);
    chk("bb_N6_mata", bus.opf_mul_mat_a, mem[3]);
    chk("bb_N6_matb", bus.opf_mul_mat_b, mem[2]);
    cyc();
    chk("bb_N7_vld", bus.opf_mul_vld, 0);

    // ---- flush in RD_A ----
    req(1'b1, 4'd7, 4'd2, 4'd3);
    cyc(); req(1'b0, 4'd0, 4'd0, 4'd0); flush(1'b1, 1'b1); #1;
    chk("fa_N1_ready", bus.alphaTensor_idu_ready, 0);
    chk("fa_N1_vld", bus.opf_mul_vld, 0);
    cyc(); flush(1'b0, 1'b0); #1;
    chk("fa_N2_ready", bus.alphaTensor_idu_ready, 1);
    chk("fa_N2_rden", bus.mmem_rd_en, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fa_vld", bus.opf_mul_vld, 0);
      chk("fa_rden", bus.mmem_rd_en, 0);
    end

    // ---- flush during HOLD; ignored flush without bru_vld ----
    bus.mul_opf_ready = 1'b0;
    req(1'b1, 4'd2, 4'd3, 4'd3);
    cyc(); req(1'b0, 4'd0, 4'd0, 4'd0);
    cyc(); cyc();
    flush(1'b0, 1'b1); #1;
    chk("fh_novld_vld", bus.opf_mul_vld, 1);
    cyc();
    flush(1'b1, 1'b1); bus.mul_opf_ready = 1'b1; req(1'b1, 4'd8, 4'd1, 4'd1); #1;
    chk("fh_vld", bus.opf_mul_vld, 0);
    chk("fh_ready", bus.alphaTensor_idu_ready, 0);
    chk("fh_rden", bus.mmem_rd_en, 0);
    cyc(); flush(1'b0, 1'b0); req(1'b0, 4'd0, 4'd0, 4'd0); #1;
    chk("fh_idle_ready", bus.alphaTensor_idu_ready, 1);
    chk("fh_idle_vld", bus.opf_mul_vld, 0);
    chk("fh_idle_rden", bus.mmem_rd_en, 0);

    // ---- request during flush in IDLE is refused, then taken; rs1==rs2 ----
    req(1'b1, 4'd9, 4'd2, 4'd2); flush(1'b1, 1'b1); #1;
    chk("fi_ready", bus.alphaTensor_idu_ready, 1);
    chk("fi_rden", bus.mmem_rd_en, 0);
    cyc(); flush(1'b0, 1'b0); #1;
    chk("fi_take_rden", bus.mmem_rd_en, 1);
    chk("fi_take_addr", bus.mmem_rd_addr, 2);
    cyc(); req(1'b0, 4'd0, 4'd0, 4'd0); #1;
    chk("fi_rd2_addr", bus.mmem_rd_addr, 2);
    cyc(); cyc();
    chk("fi_vld", bus.opf_mul_vld, 1);
    chk("fi_rd", bus.opf_mul_rd, 9);
    chk("fi_mata", bus.opf_mul_mat_a, mem[2]);
    chk("fi_matb", bus.opf_mul_mat_b, mem[2]);
    cyc();

    // ---- asynchronous reset mid-operation ----
    req(1'b1, 4'd3, 4'd2, 4'd3);
    cyc(); req(1'b0, 4'd0, 4'd0, 4'd0);
    cyc();
    rst_n = 1'b0; #1;
    chk("ar_vld", bus.opf_mul_vld, 0);
    chk("ar_rden", bus.mmem_rd_en, 0);
    chk("ar_ready", bus.alphaTensor_idu_ready, 0);
    chk("ar_rd", bus.opf_mul_rd, 0);
    chk("ar_mata", bus.opf_mul_mat_a, 0);
    cyc(); #2 rst_n = 1'b1;
    cyc();
    chk("ar_post_vld", bus.opf_mul_vld, 0);
    chk("ar_post_ready", bus.alphaTensor_idu_ready, 1);
    req(1'b1, 4'd6, 4'd3, 4'd3);
    cyc(); req(1'b0, 4'd0, 4'd0, 4'd0);
    cyc(); cyc();
    chk("ar_new_vld", bus.opf_mul_vld, 1);
    chk("ar_new_rd", bus.opf_mul_rd, 6);
    chk("ar_new_mata", bus.opf_mul_mat_a, mem[3]);
    chk("ar_new_matb", bus.opf_mul_mat_b, mem[3]);
    cyc();
    chk("ar_done_vld", bus.opf_mul_vld, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alphatensor_operand_fetch.md
Name: alphatensor_operand_fetch

Overview:
- Operand-fetch stage directly upstream of the alphaTensor 4x4 matrix multiplier.
- Accepts a matrix-multiply request from IDU (rd, rs1, rs2 indices), reads both source matrices from the single-read-port matrix memory, and presents {rd, mat_a, mat_b} to the multiplier with a valid/ready handshake.
- Kills in-flight requests on an IEX branch flush.

Parameters:
- MATRIX_MEM_DEPTH_BIT, 4, width of a matrix-memory index.
- ELEM_WIDTH, 32, bits per matrix element.
- ELEM_NUM, 16, elements per matrix (4x4). Element k occupies bits [k*ELEM_WIDTH +: ELEM_WIDTH].

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- idu_alphaTensor_rd  in  MATRIX_MEM_DEPTH_BIT  destination matrix index.
- idu_alphaTensor_rs1  in  MATRIX_MEM_DEPTH_BIT  source A index.
- idu_alphaTensor_rs2  in  MATRIX_MEM_DEPTH_BIT  source B index.
- idu_alphaTensor_mul_vld  in  1  request valid.
- alphaTensor_idu_ready  out  1  request accepted when vld&&ready.
- iex_alphaTensor_bru_vld_0  in  1  branch result valid.
- iex_alphaTensor_bru_flush_0  in  1  flush; effective only when bru_vld_0=1.
- mmem_rd_en  out  1  matrix-memory read enable.
- mmem_rd_addr  out  MATRIX_MEM_DEPTH_BIT  read index.
- mmem_rd_data  in  ELEM_WIDTH*ELEM_NUM  read data, valid the cycle after rd_en (synchronous read).
- opf_mul_vld  out  1  operands valid to the multiplier.
- mul_opf_ready  in  1  multiplier accepts.
- opf_mul_rd  out  MATRIX_MEM_DEPTH_BIT  latched rd.
- opf_mul_mat_a  out  ELEM_WIDTH*ELEM_NUM  matrix at rs1.
- opf_mul_mat_b  out  ELEM_WIDTH*ELEM_NUM  matrix at rs2.

Behaviour:
- Interface: single clock clk; asynchronous active-low reset rst_n.
- flush = bru_vld_0 & bru_flush_0. accept = mul_vld & idu_ready & ~flush.
- FSM states: IDLE, RD_A, RD_B, HOLD. Reset gives IDLE; all outputs 0; rd/rs1/rs2/mat_a/mat_b registers cleared.
- idu_ready = (IDLE) | (HOLD & mul_opf_ready & ~flush). This combinational term allows back-to-back issue.
- On accept:
  - Latch rd, rs1, rs2.
  - Drive mmem_rd_en=1, mmem_rd_addr=rs1 in the same cycle.
  - Next state RD_A.
- RD_A:
  - Capture mmem_rd_data into mat_a.
  - Drive rd_en=1, addr=latched rs2.
  - Next state RD_B.
- RD_B: capture mmem_rd_data into mat_b; next state HOLD.
- HOLD:
  - opf_mul_vld = ~flush (combinational gate).
  - mat_a, mat_b and rd are held stable until the handshake.
  - On vld&&ready: go to RD_A if accept occurred, else IDLE.
- Latency: accept in cycle N gives opf_mul_vld high in cycle N+3. Throughput: one request per 3 cycles with ready=1.
- mmem_rd_en=0 and mmem_rd_addr=0 in every cycle with no read.
- Flush:
  - In RD_A/RD_B/HOLD, go to IDLE next cycle. No output is produced and no further read is issued.
  - A request presented in a flush cycle is not accepted (idu_ready may be 1, accept=0).
  - A HOLD-state handshake cannot complete in a flush cycle: vld is forced low.
- bru_flush_0 with bru_vld_0=0 is ignored.
- rs1==rs2: two reads are still performed; mat_a==mat_b.
- mul_opf_ready high outside HOLD is ignored.
- Asynchronous reset mid-operation: immediate return to IDLE with outputs 0. No pending read is honoured after release.
- Elements are passed unmodified; no arithmetic in this block.
- RAW hazards between an in-flight rd and a later rs are resolved by IDU, not here.

Decomposition:
- Shared package alphatensor_pkg holds:
  - MATRIX_MEM_DEPTH_BIT, ELEM_WIDTH, ELEM_NUM, MAT_WIDTH=ELEM_WIDTH*ELEM_NUM.
  - matrix_t packed typedef.
  - opf_state_e enum {IDLE, RD_A, RD_B, HOLD}.
- Single module; no sub-module is warranted.

Test Plan:
- Basic fetch: mem[2] elems = {3,9,8,1,5,6,9,1,33,41,6161,3434,32535,12313,124124,46456}, mem[3] elems = 1..16. Request rd=1, rs1=2, rs2=3 at cycle N, ready=1 -> rd_en/addr 2@N, 3@N+1; opf_mul_vld only @N+3 with rd=1; mat_a elem0=3, elem15=46456; mat_b elem0=1, elem15=16.
- Flush in RD_A: flush at N+1 -> no read of rs2 issued @N+1 beyond that cycle's rd_en; state IDLE @N+2; opf_mul_vld never asserts; idu_ready=1 @N+2.
- Backpressure: ready=0 for 5 cycles from N+3 -> vld stays 1, mat_a/mat_b/rd stable, idu_ready=0; ready=1 @N+8 -> handshake, vld=0 @N+9.
- Back-to-back: second request (rd=4, rs1=3, rs2=2) held valid, handshake @N+3 -> accepted @N+3, rd_addr=3 @N+3, vld @N+6 with mat_a=mem[3], mat_b=mem[2].
- Flush during HOLD with ready=1 -> vld=0 that cycle, no handshake, IDLE next cycle; flush=1 with bru_vld_0=0 -> no effect.
- rst_n low at N+2 -> all outputs 0 immediately; after release a new request rs1=rs2=3 yields mat_a==mat_b==mem[3] 3 cycles after accept.
